// File: rtl/mat_cache_drainer_pkg.sv
// MatCachePkg: shared types for the MatCache read-side drainer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package MatCachePkg;

  localparam int MAT_WIDTH      = 4;
  localparam int MAT_CACHE_SIZE = 4;
  localparam int MAT_DATA_WIDTH = 32;

  // Cache read opcode presented alongside read_addr1/read_addr2/read_param.
  typedef enum logic [1:0] {
    MAT_CACHE_READ_NONE = 2'd0,
    MAT_CACHE_READ_ROW  = 2'd1,
    MAT_CACHE_READ_DIAG = 2'd2
  } MatCacheReadOp_t;

  typedef enum logic {
    MAT_DRAIN_ROW  = 1'b0,
    MAT_DRAIN_DIAG = 1'b1
  } MatDrainMode_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_ISSUE = 2'd1,
    DRAIN_DRAIN = 2'd2
  } MatDrainState_t;

endpackage

// File: rtl/mat_cache_drainer_fifo.sv
// mat_drain_fifo: 2-entry valid/ready FIFO for drained vectors {data, index, last}.
// Latency: push at edge N is visible at the head after edge N; head is registered storage.
// Backpressure: push refused when full unless a pop happens in the same cycle.
// Ports: clock/reset_n; push_vld/push_dat/full (write side); pop_vld/pop_rdy/pop_dat/empty (read side).
module mat_drain_fifo #(
  parameter int PW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push_vld,
  input  logic [PW-1:0] push_dat,
  output logic          full,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [PW-1:0] pop_dat,
  output logic          empty
);

  logic [PW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign pop_vld = !empty;
  assign pop_dat = mem[rd_ptr];

  assign do_pop  = pop_rdy && !empty;
  // When full, the popped slot is exactly the one wr_ptr points at, so the
  // simultaneous push safely reuses it.
  assign do_push = push_vld && (!full || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/mat_cache_drainer.sv
// mat_cache_drainer: issues WIDTH row/diagonal reads of one cached matrix and streams the vectors out.
// Latency: command accepted at edge N -> first read pushed at edge N+1, out_valid after N+1; 1 vector/cycle.
// Backpressure: 2-entry output FIFO; read_param stalls while the FIFO is full and not popping.
// Ports: clock/reset_n; cmd_valid/cmd_ready/cmd_mode/cmd_addr1/cmd_addr2 (command);
//        read_op/read_addr1/read_addr2/read_param + cache_data (combinational cache read);
//        out_valid/out_ready/out_data/out_index/out_last (vector stream); busy.
// Build option: MAT_DRAIN_OVERLAP_EN also accepts a new command during DRAIN.
module mat_cache_drainer
  import MatCachePkg::*;
#(
  parameter int WIDTH      = MAT_WIDTH,
  parameter int CACHE_SIZE = MAT_CACHE_SIZE,
  parameter int DATA_WIDTH = MAT_DATA_WIDTH
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  MatDrainMode_t                        cmd_mode,
  input  logic [$clog2(CACHE_SIZE)-1:0]        cmd_addr1,
  input  logic [$clog2(CACHE_SIZE)-1:0]        cmd_addr2,
  output MatCacheReadOp_t                      read_op,
  output logic [$clog2(CACHE_SIZE)-1:0]        read_addr1,
  output logic [$clog2(CACHE_SIZE)-1:0]        read_addr2,
  output logic [$clog2(WIDTH)-1:0]             read_param,
  input  logic [WIDTH-1:0][DATA_WIDTH-1:0]     cache_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH-1:0][DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(WIDTH)-1:0]             out_index,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int AW = $clog2(CACHE_SIZE);
  localparam int IW = $clog2(WIDTH);
  localparam int PW = WIDTH * DATA_WIDTH + IW + 1;

  MatDrainState_t state;
  MatDrainState_t state_nxt;
  MatDrainMode_t  mode_q;
  logic [AW-1:0]  addr1_q;
  logic [AW-1:0]  addr2_q;
  logic [IW-1:0]  param_q;

  logic           accept;
  logic           pop;
  logic           push;
  logic           is_last;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PW-1:0]  push_dat;
  logic [PW-1:0]  pop_dat;

  assign accept  = cmd_valid && cmd_ready;
  assign pop     = out_valid && out_ready;
  assign is_last = (param_q == IW'(WIDTH - 1));
  // A full FIFO that is popping this cycle still has room for the next read.
  assign push    = (state == DRAIN_ISSUE) && (!fifo_full || pop);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    read_op   = MAT_CACHE_READ_NONE;
    case (state)
      DRAIN_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = DRAIN_ISSUE;
      end
      DRAIN_ISSUE: begin
        read_op = (mode_q == MAT_DRAIN_DIAG) ? MAT_CACHE_READ_DIAG : MAT_CACHE_READ_ROW;
        if (push && is_last) state_nxt = DRAIN_DRAIN;
      end
      DRAIN_DRAIN: begin
        // Nothing is pushed in DRAIN, so popping the last-marked head empties the FIFO.
        if (fifo_empty || (pop && out_last)) state_nxt = DRAIN_IDLE;
`ifdef MAT_DRAIN_OVERLAP_EN
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = DRAIN_ISSUE;
`endif
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= DRAIN_IDLE;
      mode_q  <= MAT_DRAIN_ROW;
      addr1_q <= '0;
      addr2_q <= '0;
      param_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q  <= cmd_mode;
        addr1_q <= cmd_addr1;
        addr2_q <= cmd_addr2;
        param_q <= '0;
      end else if (push) begin
        param_q <= param_q + IW'(1);
      end
    end
  end

  assign read_addr1 = addr1_q;
  assign read_addr2 = addr2_q;
  assign read_param = param_q;
  assign busy       = (state != DRAIN_IDLE) || !fifo_empty;

  // Cache contents are captured at push time; later writes only affect later vectors.
  assign push_dat = {cache_data, param_q, is_last};
  assign {out_data, out_index, out_last} = pop_dat;

  mat_drain_fifo #(
    .PW (PW)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push_vld (push),
    .push_dat (push_dat),
    .full     (fifo_full),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (pop_dat),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_mat_cache_drainer.sv
// tb_mat_cache_drainer: directed bench for mat_cache_drainer with a combinational cache model.
// Latency: n/a.
// Backpressure: out_ready driven per step.
module tb_mat_cache_drainer;
  import MatCachePkg::*;

  localparam int W  = 4;
  localparam int CS = 4;
  localparam int DW = 32;

  typedef logic [W-1:0][DW-1:0] vec_t;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  MatDrainMode_t   cmd_mode = MAT_DRAIN_ROW;
  logic [1:0]      cmd_addr1 = '0;
  logic [1:0]      cmd_addr2 = '0;
  MatCacheReadOp_t read_op;
  logic [1:0]      read_addr1;
  logic [1:0]      read_addr2;
  logic [1:0]      read_param;
  vec_t            cache_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  vec_t            out_data;
  logic [1:0]      out_index;
  logic            out_last;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic acc_pend = 1'b0;

  logic [DW-1:0] mem [CS][W][W];
  vec_t rows0 [4];
  vec_t diag0 [4];
  vec_t rows1 [4];
  vec_t zero_v;

  vec_t       g_dat  [$];
  logic [1:0] g_idx  [$];
  logic       g_last [$];
  int         g_cyc  [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mat_cache_drainer #(.WIDTH(W), .CACHE_SIZE(CS), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2),
    .read_op(read_op), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_param(read_param), .cache_data(cache_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  // Cache model: diagonal i, element j = M[j][(i - j) mod W].
  always_comb begin
    cache_data = '0;
    for (int j = 0; j < W; j++) begin
      case (read_op)
        MAT_CACHE_READ_ROW:  cache_data[j] = mem[read_addr1][read_param][j];
        MAT_CACHE_READ_DIAG: cache_data[j] = mem[read_addr1][j][2'(read_param - 2'(j))];
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] fenc(input int n);
    case (n)
      1: fenc = 32'h3F80_0000;
      2: fenc = 32'h4000_0000;
      3: fenc = 32'h4040_0000;
      4: fenc = 32'h4080_0000;
      5: fenc = 32'h40A0_0000;
      6: fenc = 32'h40C0_0000;
      7: fenc = 32'h40E0_0000;
      9: fenc = 32'h4110_0000;
      default: fenc = 32'h0000_0000;
    endcase
  endfunction

  function automatic vec_t v4(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = fenc(a); v[1] = fenc(b); v[2] = fenc(c); v[3] = fenc(d);
    return v;
  endfunction

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input vec_t obs, input vec_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set; records handshakes until n
  // vectors are seen or the cycle budget runs out. Returns at the negedge of
  // the n-th handshake. Drops cmd_valid on the negedge after an acceptance.
  task automatic collect(input string tag, input int n);
    int waited = 0;
    g_dat = {}; g_idx = {}; g_last = {}; g_cyc = {};
    forever begin
      if (acc_pend) cmd_valid = 1'b0;
      acc_pend = cmd_valid && cmd_ready;
      if (out_valid && out_ready) begin
        g_dat.push_back(out_data);
        g_idx.push_back(out_index);
        g_last.push_back(out_last);
        g_cyc.push_back(cyc);
      end
      if (g_dat.size() >= n || waited >= 40) break;
      @(negedge clock);
      waited++;
    end
    chkn({tag, "_count"}, 32'(g_dat.size()), 32'(n));
  endtask

  task automatic chk_batch(input string tag, input vec_t ex [4]);
    for (int i = 0; i < 4; i++) begin
      if (i < g_dat.size()) begin
        chkv($sformatf("%s_dat%0d", tag, i), g_dat[i], ex[i]);
        chkn($sformatf("%s_idx%0d", tag, i), 32'(g_idx[i]), 32'(i));
        chkn($sformatf("%s_last%0d", tag, i), 32'(g_last[i]), (i == 3) ? 32'd1 : 32'd0);
      end
    end
    chkn({tag, "_span"}, (g_cyc.size() == 4) ? 32'(g_cyc[3] - g_cyc[0]) : 32'hFFFF_FFFF, 32'd3);
  endtask

  initial begin
    int c0;
    int last1;

    // Slot 0: the reference matrix; slot 1: tagged raw words per (row, col).
    mem[0][0] = '{fenc(4), fenc(6), fenc(1), fenc(6)};
    mem[0][1] = '{fenc(1), fenc(2), fenc(3), fenc(4)};
    mem[0][2] = '{fenc(3), fenc(3), fenc(3), fenc(3)};
    mem[0][3] = '{fenc(9), fenc(7), fenc(5), fenc(3)};
    for (int s = 1; s < CS; s++)
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++)
          mem[s][r][c] = 32'hA000_0000 + 32'(s * 256 + r * 16 + c);

    rows0 = '{v4(4,6,1,6), v4(1,2,3,4), v4(3,3,3,3), v4(9,7,5,3)};
    diag0 = '{v4(4,4,3,7), v4(6,1,3,5), v4(1,2,3,3), v4(6,3,3,9)};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        rows1[r][c] = 32'hA000_0100 + 32'(r * 16 + c);
    zero_v = '0;

    // ---- reset values
    @(negedge clock);
    chkn("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chkn("rst_out_valid", 32'(out_valid), 32'd0);
    chkn("rst_busy", 32'(busy), 32'd0);
    chkn("rst_read_op", 32'(read_op), 32'(MAT_CACHE_READ_NONE));
    chkn("rst_read_addr1", 32'(read_addr1), 32'd0);
    chkn("rst_read_addr2", 32'(read_addr2), 32'd0);
    chkn("rst_read_param", 32'(read_param), 32'd0);
    chkv("rst_out_data", out_data, zero_v);
    chkn("rst_out_index", 32'(out_index), 32'd0);
    chkn("rst_out_last", 32'(out_last), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // ---- row drain, out_ready high
    cmd_valid = 1'b1; cmd_mode = MAT_DRAIN_ROW; cmd_addr1 = 2'd0; cmd_addr2 = 2'd0;
    out_ready = 1'b1;
    c0 = cyc;
    collect("row", 4);
    chk_batch("row", rows0);
    chkn("row_latency", (g_cyc.size() > 0) ? 32'(g_cyc[0] - c0) : 32'hFFFF_FFFF, 32'd2);
    @(negedge clock);
    chkn("row_idle_busy", 32'(busy), 32'd0);
    chkn("row_idle_ready", 32'(cmd_ready), 32'd1);
    chkn("row_idle_valid", 32'(out_valid), 32'd0);

    // ---- backpressure: out_ready low from acceptance through 5 cycles after first push
    cmd_valid = 1'b1; cmd_mode = MAT_DRAIN_ROW; cmd_addr1 = 2'd0;
    out_ready = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    chkn("bp_param0", 32'(read_param), 32'd0);
    chkn("bp_read_op", 32'(read_op), 32'(MAT_CACHE_READ_ROW));
    repeat (4) @(negedge clock);
    chkn("bp_stall_a", 32'(read_param), 32'd2);
    chkn("bp_valid", 32'(out_valid), 32'd1);
    chkn("bp_head_idx", 32'(out_index), 32'd0);
    chkv("bp_head_dat", out_data, rows0[0]);
    @(negedge clock);
    chkn("bp_stall_b", 32'(read_param), 32'd2);
    chkv("bp_hold_dat", out_data, rows0[0]);
    out_ready = 1'b1;
    acc_pend = 1'b0;
    collect("bp", 4);
    chk_batch("bp", rows0);
    @(negedge clock);
    chkn("bp_idle_busy", 32'(busy), 32'd0);

    // ---- command while busy: second (diagonal) command held during ISSUE
    cmd_valid = 1'b1; cmd_mode = MAT_DRAIN_ROW; cmd_addr1 = 2'd1; cmd_addr2 = 2'd3;
    @(negedge clock);
    chkn("busy_ready_issue", 32'(cmd_ready), 32'd0);
    chkn("busy_read_addr1", 32'(read_addr1), 32'd1);
    chkn("busy_read_addr2", 32'(read_addr2), 32'd3);
    cmd_valid = 1'b1; cmd_mode = MAT_DRAIN_DIAG; cmd_addr1 = 2'd0; cmd_addr2 = 2'd0;
    acc_pend = 1'b0;
    collect("busy1", 4);
    chk_batch("busy1", rows1);
    last1 = (g_cyc.size() == 4) ? g_cyc[3] : 0;
`ifdef MAT_DRAIN_OVERLAP_EN
    chkn("busy_ready_drain", 32'(cmd_ready), 32'd1);
`else
    chkn("busy_ready_drain", 32'(cmd_ready), 32'd0);
`endif
    @(negedge clock);
    collect("diag", 4);
    chk_batch("diag", diag0);
`ifdef MAT_DRAIN_OVERLAP_EN
    chkn("diag_gap", (g_cyc.size() > 0) ? 32'(g_cyc[0] - last1) : 32'hFFFF_FFFF, 32'd2);
`else
    chkn("diag_gap", (g_cyc.size() > 0) ? 32'(g_cyc[0] - last1) : 32'hFFFF_FFFF, 32'd3);
`endif
    @(negedge clock);
    chkn("diag_idle_busy", 32'(busy), 32'd0);

    // ---- reset mid-command
    cmd_valid = 1'b1; cmd_mode = MAT_DRAIN_ROW; cmd_addr1 = 2'd1; cmd_addr2 = 2'd2;
    collect("rstmid", 2);
    reset_n = 1'b0;
    #1;
    chkn("rstmid_valid", 32'(out_valid), 32'd0);
    chkn("rstmid_busy", 32'(busy), 32'd0);
    chkn("rstmid_ready", 32'(cmd_ready), 32'd1);
    chkn("rstmid_read_op", 32'(read_op), 32'(MAT_CACHE_READ_NONE));
    chkn("rstmid_addr1", 32'(read_addr1), 32'd0);
    chkn("rstmid_param", 32'(read_param), 32'd0);
    cmd_valid = 1'b0;
    acc_pend = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_mode = MAT_DRAIN_ROW; cmd_addr1 = 2'd0; cmd_addr2 = 2'd0;
    collect("after_rst", 4);
    chk_batch("after_rst", rows0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
